// File: rtl/ex_btc_minmax_acc_pkg.sv
// ex_btc_minmax_acc_pkg: shared BTC definitions for the min/max block accumulator.
//   state_t   : accumulator FSM encoding (IDLE=0, ACCUM=1, HOLD=2)
//   BEATS     : accepted beats per 4x4 block
//   btc_key   : 8-bit ordering key of an RGB555 pixel
package ex_btc_minmax_acc_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ACCUM = 2'd1,
        HOLD  = 2'd2
    } state_t;

    localparam int BEATS = 4;

    // Interleaved high bits of the three channels give a cheap luma-like order.
    function automatic logic [7:0] btc_key(input logic [14:0] p);
        return {p[9], p[8], p[14], p[4], p[7], p[13], p[3], p[6]};
    endfunction

endpackage

// File: rtl/ex_btc_minmax4.sv
// ex_btc_minmax4: combinational min/max-by-key over the four lanes of one beat.
//   lanes : four 15-bit RGB555 pixels, lane 0 in [0]
//   mn    : pixel with the smallest key (lowest lane wins ties)
//   mx    : pixel with the largest key (lowest lane wins ties)
module ex_btc_minmax4
    import ex_btc_minmax_acc_pkg::*;
(
    input  logic [3:0][14:0] lanes,
    output logic [14:0]      mn,
    output logic [14:0]      mx
);

    // Strict compares while walking lane0..lane3 keep the lowest lane on ties.
    always_comb begin
        mn = lanes[0];
        mx = lanes[0];
        for (int i = 1; i < 4; i++) begin
            mn = (btc_key(lanes[i]) < btc_key(mn)) ? lanes[i] : mn;
            mx = (btc_key(lanes[i]) > btc_key(mx)) ? lanes[i] : mx;
        end
    end

endmodule

// File: rtl/ex_btc_minmax_acc.sv
// ex_btc_minmax_acc: accumulates 4 beats of 4 RGB555 pixels into min/max endpoints.
//   clock, reset        : single clock, synchronous active-high reset
//   inValid/inReady     : pixel beat handshake, inPix = 4 lanes of RGB555 (bit 15 ignored)
//   outValid/outReady   : result handshake, outMinMax = {0,min,0,max}
//   outFlat             : min key equals max key (only with JX2_BTC_MINMAX_FLAT_EN, else 0)
//   outBeats            : beats accepted for the current block, modulo 4
module ex_btc_minmax_acc
    import ex_btc_minmax_acc_pkg::*;
(
    input  logic        clock,
    input  logic        reset,
    input  logic        inValid,
    output logic        inReady,
    input  logic [63:0] inPix,
    output logic        outValid,
    input  logic        outReady,
    output logic [31:0] outMinMax,
    output logic        outFlat,
    output logic [1:0]  outBeats
);

    state_t           state_q, state_d;
    logic [1:0]       cnt_q, cnt_d;
    logic [14:0]      mn_q, mn_d, mx_q, mx_d;
    logic [31:0]      res_q, res_d;
    logic [3:0][14:0] lanes;
    logic [14:0]      bmn, bmx, fmn, fmx;
    logic             acc, first;
    logic             unused_msb;

    assign lanes      = {inPix[62:48], inPix[46:32], inPix[30:16], inPix[14:0]};
    assign unused_msb = ^{inPix[63], inPix[47], inPix[31], inPix[15]};

    ex_btc_minmax4 u_red (
        .lanes (lanes),
        .mn    (bmn),
        .mx    (bmx)
    );

    assign outValid  = state_q == HOLD;
    assign inReady   = !outValid || outReady;
    assign outMinMax = res_q;
    assign outBeats  = cnt_q;
    assign acc       = inValid && inReady;
    // Outside ACCUM an accepted beat starts a fresh block from that beat alone.
    assign first     = state_q != ACCUM;

    // Earlier beats win ties because the accumulator is only replaced on strict compares.
    always_comb begin
        fmn     = (first || btc_key(bmn) < btc_key(mn_q)) ? bmn : mn_q;
        fmx     = (first || btc_key(bmx) > btc_key(mx_q)) ? bmx : mx_q;
        state_d = (state_q == HOLD && outReady) ? IDLE : state_q;
        cnt_d   = cnt_q;
        mn_d    = mn_q;
        mx_d    = mx_q;
        res_d   = res_q;
        if (acc) begin
            mn_d    = fmn;
            mx_d    = fmx;
            cnt_d   = cnt_q + 2'd1;
            state_d = ACCUM;
            if (cnt_q == 2'(BEATS - 1)) begin
                res_d   = {1'b0, fmn, 1'b0, fmx};
                state_d = HOLD;
            end
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            mn_q    <= '0;
            mx_q    <= '0;
            res_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            mn_q    <= mn_d;
            mx_q    <= mx_d;
            res_q   <= res_d;
        end
    end

`ifdef JX2_BTC_MINMAX_FLAT_EN
    logic flat_q, flat_d;

    always_comb begin
        flat_d = (acc && cnt_q == 2'(BEATS - 1)) ? (btc_key(fmn) == btc_key(fmx)) : flat_q;
    end

    always_ff @(posedge clock) begin
        if (reset) flat_q <= 1'b0;
        else       flat_q <= flat_d;
    end

    assign outFlat = flat_q;
`else
    assign outFlat = 1'b0;
`endif

endmodule

// File: doc/ex_btc_minmax_acc.md
EX_BTC_MINMAX_ACC -- requirements
Module: ex_btc_minmax_acc

Interface
REQ-001 SHALL have port clock, input, 1, single clock; all state updates on its rising edge.
REQ-002 SHALL have port reset, input, 1, synchronous, active-high reset.
REQ-003 SHALL have port inValid, input, 1, a pixel beat is offered.
REQ-004 SHALL have port inReady, output, 1, the block can take a beat this cycle.
REQ-005 SHALL have port inPix, input, 64, four RGB555 pixels, lane n in [16n+15:16n], bit 15 ignored.
REQ-006 SHALL have port outValid, output, 1, a min/max result is held.
REQ-007 SHALL have port outReady, input, 1, downstream takes the result.
REQ-008 SHALL have port outMinMax, output, 32, {min RGB555 in [31:16], max RGB555 in [15:0]}, bit 15 of each half zero; this is the endpoint word the color-cell index encoder consumes.
REQ-009 SHALL have port outFlat, output, 1, min key equals max key.
REQ-010 SHALL have port outBeats, output, 2, diagnostic beat counter.

Function
REQ-011 SHALL build an 8-bit key per pixel from RGB555 bits {p[9],p[8],p[14],p[4],p[7],p[13],p[3],p[6]}, MSB first.
REQ-012 SHALL form a 4x4 block from exactly 4 accepted beats, counted by a 2-bit counter that wraps 3->0.
REQ-013 SHALL accept a beat only when inValid && inReady.
REQ-014 SHALL drive inReady = !outValid || outReady.
REQ-015 SHALL use three states: IDLE, ACCUM and HOLD.
REQ-016 In IDLE, an accepted beat SHALL load the accumulators from that beat alone, set the counter to 1 and move to ACCUM.
REQ-017 In ACCUM, an accepted beat SHALL fold its 4 lanes into the accumulators and increment the counter.
REQ-018 The 4th beat (counter==3) SHALL register the result, set outValid and move to HOLD.
REQ-019 The min SHALL update only on a strictly smaller key and the max only on a strictly larger key, so ties keep the earliest beat and then the lowest lane.
REQ-020 Within a beat, lanes SHALL be reduced lane0..lane3 with the same tie rule.
REQ-021 Latency SHALL be: outValid high in the cycle after the 4th beat is accepted.
REQ-022 outMinMax and outFlat SHALL stay stable while outValid && !outReady.
REQ-023 In HOLD, outValid && outReady SHALL clear outValid (return to IDLE) in the same edge.
REQ-024 If a beat is also accepted in that cycle, it SHALL start a new block as in IDLE, with no bubble.
REQ-025 inValid low mid-block SHALL stall without losing the partial accumulation.
REQ-026 outBeats SHALL equal the number of beats accepted for the current block, modulo 4.

Reset
REQ-027 reset SHALL force state IDLE, counter 0, outValid 0, outMinMax 0, outFlat 0 and outBeats 0.
REQ-028 inReady SHALL be 1 out of reset.
REQ-029 reset SHALL take priority over any handshake in the same cycle.
REQ-030 reset mid-block or in HOLD SHALL discard the partial or pending result.

Configuration
REQ-031 Macro JX2_BTC_MINMAX_FLAT_EN SHALL control flat detection.
REQ-032 When the macro is defined, outFlat SHALL be registered with the result as (minKey==maxKey).
REQ-033 When the macro is not defined, outFlat SHALL be tied 0 and no key comparator SHALL exist for it.
REQ-034 The port list SHALL be identical with and without the macro.

Structure
REQ-035 The key-shuffle function, the state encodings (IDLE=0, ACCUM=1, HOLD=2) and the beats-per-block constant (4) SHALL live in the shared BTC package.
REQ-036 One sub-module, ex_btc_minmax4, SHALL perform the combinational 4-lane min/max-by-key reduction, instantiated once.

Verification
REQ-037 Scenario: 4 beats of pixel 0x1234 everywhere -> one cycle after beat 4, outMinMax=0x12341234 and outFlat=1 (with the macro).
REQ-038 Scenario: beat0 lane2=0x7FFF, beat3 lane1=0x0000, all others 0x4210 -> outMinMax=0x00007FFF.
REQ-039 Scenario: tie, two pixels 0x0001 and 0x0002 whose keys are equal (bits 0/1 are not in the key) -> both min and max report the earliest, 0x0001.
REQ-040 Scenario: outReady held low for 5 cycles after a result -> inReady=0, outMinMax unchanged; outReady=1 with inValid=1 -> result dropped and the next block's beat 0 accepted in the same cycle.
REQ-041 Scenario: reset asserted after 2 beats -> outBeats=0, IDLE; the next 4 beats yield a result from those beats only.
REQ-042 Scenario: inValid toggled 1/0 each cycle over a block -> result identical to a gapless stream, outValid after the 4th accepted beat.
